// File: rtl/lsu_unit.sv
// lsu_unit: load/store unit between the execute stage and data memory.
// Accepts one request per handshake, builds byte enables and lane-shifted
// store data, and aligns/extends load data from a req/gnt + rvalid memory port.
// Optional feature macro: LSU_MISALIGNED_SPLIT_EN. When defined, misaligned
// accesses are performed: one beat inside a word, two beats across a word
// boundary. When undefined, any misaligned access returns rsp_err.
module lsu_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned BE2_W = 2 * NB;
  localparam int unsigned WD2_W = 2 * XLEN;
  localparam bit          DWORD_OK = (XLEN >= 64);
`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam bit          SPLIT_EN = 1'b1;
`else
  localparam bit          SPLIT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE1 = 3'd1,
    S_WAIT1  = 3'd2,
    S_ISSUE2 = 3'd3,
    S_WAIT2  = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_we;
  logic [1:0]          r_size;
  logic                r_uns;
  logic [OFF_W-1:0]    r_off;
  logic                r_err;
  logic                r_split;
  logic [ADDR_W-1:0]   r_addr1;
  logic [ADDR_W-1:0]   r_addr2;
  logic [NB-1:0]       r_be1;
  logic [NB-1:0]       r_be2;
  logic [XLEN-1:0]     r_wd1;
  logic [XLEN-1:0]     r_wd2;
  logic [XLEN-1:0]     r_rd1;
  logic [XLEN-1:0]     r_rdata;

  logic [OFF_W-1:0]    w_off;
  logic [3:0]          w_nbytes;
  logic [BE2_W-1:0]    w_be_full;
  logic [WD2_W-1:0]    w_wd_full;
  logic [ADDR_W-1:0]   w_word;
  logic [ADDR_W-1:0]   w_word2;
  logic                w_illegal;
  logic                w_misal;
  logic                w_cross;
  logic                w_err;
  logic                w_accept;

  // Shift the two-word window down by the byte offset, keep the access bytes, extend.
  function automatic logic [XLEN-1:0] f_load(
    input logic [XLEN-1:0]  lo,
    input logic [XLEN-1:0]  hi,
    input logic [OFF_W-1:0] off,
    input logic [1:0]       size,
    input logic             uns
  );
    logic [WD2_W-1:0] sh;
    logic [XLEN-1:0]  res;
    int unsigned      nbits;
    logic             sgn;
    sh    = {hi, lo} >> {off, 3'b000};
    nbits = 32'd8 << size;
    sgn   = 1'b0;
    res   = '0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      if (!uns && (i + 32'd1 == nbits)) sgn = sh[i];
    end
    for (int unsigned i = 0; i < XLEN; i++) begin
      res[i] = (i < nbits) ? sh[i] : sgn;
    end
    return res;
  endfunction

  // Request decode: lane mask, shifted data, word addresses and error class.
  always_comb begin
    w_off     = req_addr[OFF_W-1:0];
    w_nbytes  = 4'd1 << req_size;
    w_be_full = BE2_W'((32'd1 << w_nbytes) - 32'd1) << w_off;
    w_wd_full = WD2_W'(req_wdata) << {w_off, 3'b000};
    w_word    = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    w_word2   = w_word + ADDR_W'(NB);
    w_illegal = (req_size == 2'd3) && !DWORD_OK;
    w_misal   = ((32'(w_off) & (32'(w_nbytes) - 32'd1)) != 32'd0);
    w_cross   = |w_be_full[BE2_W-1:NB];
    w_err     = w_illegal | (w_misal & !SPLIT_EN);
    w_accept  = req_valid && (r_state == S_IDLE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (req_valid)  w_state_nxt = w_err ? S_RESP : S_ISSUE1;
      S_ISSUE1: if (mem_gnt)    w_state_nxt = S_WAIT1;
      S_WAIT1:  if (mem_rvalid) w_state_nxt = r_split ? S_ISSUE2 : S_RESP;
      S_ISSUE2: if (mem_gnt)    w_state_nxt = S_WAIT2;
      S_WAIT2:  if (mem_rvalid) w_state_nxt = S_RESP;
      S_RESP:   if (rsp_ready)  w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state and latched transaction fields.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      S_IDLE: req_ready = 1'b1;
      S_ISSUE1: begin
        mem_req   = 1'b1;
        mem_we    = r_we;
        mem_be    = r_be1;
        mem_addr  = r_addr1;
        mem_wdata = r_wd1;
      end
      S_ISSUE2: begin
        mem_req   = 1'b1;
        mem_we    = r_we;
        mem_be    = r_be2;
        mem_addr  = r_addr2;
        mem_wdata = r_wd2;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = r_rdata;
        rsp_err   = r_err;
      end
      default: ;
    endcase
  end

  // Transaction fields: latched on accept, load data captured per beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_size  <= 2'd0;
      r_uns   <= 1'b0;
      r_off   <= '0;
      r_err   <= 1'b0;
      r_split <= 1'b0;
      r_addr1 <= '0;
      r_addr2 <= '0;
      r_be1   <= '0;
      r_be2   <= '0;
      r_wd1   <= '0;
      r_wd2   <= '0;
      r_rd1   <= '0;
      r_rdata <= '0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_size  <= req_size;
      r_uns   <= req_unsigned;
      r_off   <= w_off;
      r_err   <= w_err;
      r_split <= w_cross & SPLIT_EN;
      r_addr1 <= w_word;
      r_addr2 <= w_word2;
      r_be1   <= w_be_full[NB-1:0];
      r_be2   <= w_be_full[BE2_W-1:NB];
      r_wd1   <= w_wd_full[XLEN-1:0];
      r_wd2   <= w_wd_full[WD2_W-1:XLEN];
      r_rdata <= '0;
    end else if (mem_rvalid && (r_state == S_WAIT1)) begin
      r_rd1 <= mem_rdata;
      if (!r_split) r_rdata <= r_we ? '0 : f_load(mem_rdata, '0, r_off, r_size, r_uns);
    end else if (mem_rvalid && (r_state == S_WAIT2)) begin
      r_rdata <= r_we ? '0 : f_load(r_rd1, mem_rdata, r_off, r_size, r_uns);
    end
  end

endmodule

// File: tb/tb_lsu_unit.sv
// tb_lsu_unit: directed bench for lsu_unit with a byte-level reference model,
// a reactive memory responder, and a per-cycle compare process.
module tb_lsu_unit;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned NB     = XLEN / 8;
`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;
  logic              mem_req;
  logic              mem_we;
  logic [NB-1:0]     mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  lsu_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory seen by the DUT, and the model's own view of memory.
  logic [7:0] dut_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] dut_rd(input logic [31:0] a);
    return dut_mem.exists(a) ? dut_mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] lmask(input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{be[i]}};
    return r;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      dut_mem[a + 32'(i)] = w[8*i +: 8];
      ref_mem[a + 32'(i)] = w[8*i +: 8];
    end
  endtask

  // Model expectations for the transaction in flight.
  logic        exp_err;
  logic        exp_we;
  logic [31:0] exp_rdata;
  int          exp_nb;
  logic [31:0] exp_addr [2];
  logic [3:0]  exp_be   [2];
  logic [31:0] exp_wd   [2];
  bit          busy = 1'b0;
  int          beat_idx = 0;

  // Byte-level view: access covers bytes addr..addr+n-1, grouped by word.
  task automatic model_setup(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
    int          n;
    logic [31:0] a;
    logic [31:0] w;
    logic [63:0] v;
    logic [63:0] m;
    n         = 1 << size;
    exp_we    = we;
    exp_err   = (size == 2'd3) || (!SPLIT && ((addr % 32'(n)) != 32'd0));
    exp_nb    = 0;
    exp_rdata = '0;
    v         = '0;
    if (!exp_err) begin
      for (int i = 0; i < n; i++) begin
        a = addr + 32'(i);
        w = {a[31:2], 2'b00};
        if (exp_nb == 0 || exp_addr[exp_nb-1] != w) begin
          exp_addr[exp_nb] = w;
          exp_be[exp_nb]   = '0;
          exp_wd[exp_nb]   = '0;
          exp_nb++;
        end
        exp_be[exp_nb-1][a[1:0]]       = 1'b1;
        exp_wd[exp_nb-1][8*a[1:0] +: 8] = wdata[8*i +: 8];
        if (we) ref_mem[a] = wdata[8*i +: 8];
        else    v[8*i +: 8] = ref_rd(a);
      end
      if (!we) begin
        m = (64'd1 << (8*n)) - 64'd1;
        if (!uns && v[8*n-1]) v = v | ~m;
        exp_rdata = v[31:0];
      end
    end
  endtask

  // Reactive memory: grant after cfg_gd cycles of mem_req, rvalid cfg_rd cycles after grant.
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wd;
  } beat_t;
  beat_t       log_q [$];
  int          cfg_gd = 0;
  int          cfg_rd = 0;
  bit          pend   = 1'b0;
  bit          gflag  = 1'b0;
  int          pcnt   = 0;
  int          gwait  = 0;
  logic [31:0] pdata  = '0;

  initial begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      mem_gnt    = 1'b0;
      if (gflag) begin
        beat_idx++;
        gflag = 1'b0;
      end
      if (pend) begin
        if (pcnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = pdata;
          pend       = 1'b0;
        end else begin
          pcnt--;
        end
      end else if (mem_req && rst_n) begin
        if (gwait >= cfg_gd) begin
          mem_gnt = 1'b1;
          gflag   = 1'b1;
          gwait   = 0;
          log_q.push_back('{addr: mem_addr, be: mem_be, we: mem_we, wd: mem_wdata});
          for (int i = 0; i < 4; i++) pdata[8*i +: 8] = dut_rd(mem_addr + 32'(i));
          if (mem_we)
            for (int i = 0; i < 4; i++)
              if (mem_be[i]) dut_mem[mem_addr + 32'(i)] = mem_wdata[8*i +: 8];
          pend = 1'b1;
          pcnt = cfg_rd;
        end else begin
          gwait++;
        end
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) begin
        chk("req_ready_busy", 64'(req_ready), 64'd0);
        if (mem_req) begin
          chk("mem_req_on_err", 64'(exp_err), 64'd0);
          chk("mem_beat_in_range", 64'(beat_idx < exp_nb), 64'd1);
          if (beat_idx < exp_nb) begin
            chk("mem_addr", 64'(mem_addr), 64'(exp_addr[beat_idx]));
            chk("mem_be", 64'(mem_be), 64'(exp_be[beat_idx]));
            chk("mem_we", 64'(mem_we), 64'(exp_we));
            if (exp_we)
              chk("mem_wdata", 64'(mem_wdata & lmask(exp_be[beat_idx])), 64'(exp_wd[beat_idx]));
          end
        end
        if (rsp_valid) begin
          chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
          chk("rsp_err", 64'(rsp_err), 64'(exp_err));
          chk("rsp_beats_done", 64'(beat_idx), 64'(exp_nb));
        end
      end else begin
        chk("idle_req_ready", 64'(req_ready), 64'd1);
        chk("idle_mem_req", 64'(mem_req), 64'd0);
        chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);
      end
    end
  end

  // One full transaction: present, accept, wait for response, hold, complete.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int gd, input int rd, input int hold,
                        output logic [31:0] rdata, output logic err);
    int lat;
    int exp_lat;
    model_setup(we, size, uns, addr, wdata);
    cfg_gd   = gd;
    cfg_rd   = rd;
    beat_idx = 0;
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk);
    #1;
    busy         = 1'b1;
    req_valid    = 1'b0;
    req_we       = ~we;
    req_size     = ~size;
    req_unsigned = ~uns;
    req_addr     = ~addr;
    req_wdata    = ~wdata;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    exp_lat = exp_err ? 1 : 1 + exp_nb * (2 + gd + rd);
    chk("rsp_latency", 64'(lat), 64'(exp_lat));
    rdata = rsp_rdata;
    err   = rsp_err;
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    busy      = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [31:0] rd;
    logic        err;

    vecs[0]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0201, 32'h0000_00A5};
    vecs[1]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h0000_BEEF};
    vecs[2]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0};
    vecs[3]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0202, 32'h0};
    vecs[4]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0202, 32'h0};
    vecs[5]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0201, 32'h0};
    vecs[6]  = '{1'b0, 2'd3, 1'b0, 32'h0000_0200, 32'h0};
    vecs[7]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0201, 32'h0};
    vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h0000_020E, 32'h0102_0304};
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h0000_020C, 32'h0};
    vecs[10] = '{1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0};
    vecs[11] = '{1'b1, 2'd2, 1'b0, 32'h0000_0300, 32'hCAFE_F00D};

    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    rsp_ready    = 1'b0;
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_be", 64'(mem_be), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // LW aligned, immediate memory.
    preload(32'h100, 32'hDEAD_BEEF);
    log_q.delete();
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 0, 0, rd, err);
    chk("t1_rdata", 64'(rd), 64'hDEAD_BEEF);
    chk("t1_beats", 64'(log_q.size()), 64'd1);
    if (log_q.size() > 0) begin
      chk("t1_be", 64'(log_q[0].be), 64'hF);
      chk("t1_addr", 64'(log_q[0].addr), 64'h100);
    end

    // LB / LBU on the top lane.
    preload(32'h100, 32'h80FF_FFFF);
    log_q.delete();
    do_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, 0, 0, rd, err);
    chk("t2_lb", 64'(rd), 64'hFFFF_FF80);
    if (log_q.size() > 0) chk("t2_be", 64'(log_q[0].be), 64'h8);
    do_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, 0, 0, rd, err);
    chk("t2_lbu", 64'(rd), 64'h80);

    // SH to upper half.
    log_q.delete();
    do_req(1'b1, 2'd1, 1'b0, 32'h102, 32'h1234, 0, 0, 0, rd, err);
    chk("t3_beats", 64'(log_q.size()), 64'd1);
    if (log_q.size() > 0) begin
      chk("t3_addr", 64'(log_q[0].addr), 64'h100);
      chk("t3_be", 64'(log_q[0].be), 64'hC);
      chk("t3_wdata", 64'(log_q[0].wd), 64'h1234_0000);
    end
    chk("t3_rsp", 64'({err, rd}), 64'd0);

    // LW crossing a word boundary.
    preload(32'h100, 32'hAABB_CCDD);
    preload(32'h104, 32'h1122_3344);
    log_q.delete();
    do_req(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 0, 0, 0, rd, err);
`ifdef LSU_MISALIGNED_SPLIT_EN
    chk("t4_rdata", 64'(rd), 64'h3344_AABB);
    chk("t4_err", 64'(err), 64'd0);
    chk("t4_beats", 64'(log_q.size()), 64'd2);
    if (log_q.size() > 1) begin
      chk("t4_addr0", 64'(log_q[0].addr), 64'h100);
      chk("t4_be0", 64'(log_q[0].be), 64'hC);
      chk("t4_addr1", 64'(log_q[1].addr), 64'h104);
      chk("t4_be1", 64'(log_q[1].be), 64'h3);
    end
`else
    chk("t4_err", 64'(err), 64'd1);
    chk("t4_rdata", 64'(rd), 64'd0);
    chk("t4_no_mem_req", 64'(log_q.size()), 64'd0);
`endif

    // Delayed grant and delayed response acceptance.
    do_req(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 4, 2, 3, rd, err);
    chk("t5_rdata", 64'(rd), 64'h1122_3344);

    // Mixed traffic with varying memory and consumer timing.
    for (int i = 0; i < 12; i++) begin
      do_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wd,
             i % 3, (i + 1) % 2, i % 2, rd, err);
    end
    do_req(1'b0, 2'd0, 1'b1, 32'h302, 32'h0, 0, 0, 0, rd, err);
    chk("t7_lbu_fe", 64'(rd), 64'hFE);

    // Reset while waiting for read data.
    model_setup(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    cfg_gd   = 0;
    cfg_rd   = 6;
    beat_idx = 0;
    log_q.delete();
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = 1'b0;
    req_size     = 2'd2;
    req_unsigned = 1'b0;
    req_addr     = 32'h100;
    req_wdata    = '0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    busy      = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_granted", 64'(log_q.size()), 64'd1);
    #2;
    rst_n = 1'b0;
    busy  = 1'b0;
    pend  = 1'b0;
    gflag = 1'b0;
    gwait = 0;
    #1;
    chk("t6_rst_mem_req", 64'(mem_req), 64'd0);
    chk("t6_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t6_rst_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 0, 0, rd, err);
    chk("t6_after_rst", 64'(rd), 64'hAABB_CCDD);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
